// File: rtl/common_types_pkg.sv
// Shared types for the pipeline memory path: 32-bit words and the arbiter state encoding.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DONE
  } arb_state_t;

  localparam logic [3:0] STRB_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory sides of mem_arbiter, with views for the arbiter, memory and bench.
interface mem_arbiter_if (
  input logic clk
);
  import common_types_pkg::*;

  logic       rst;
  logic       iren;
  word_t      iaddr;
  word_t      iload;
  logic       ihit;
  logic       dren;
  logic       dwen;
  word_t      daddr;
  word_t      dstore;
  logic [3:0] dstrb;
  word_t      dload;
  logic       dhit;
  logic       mem_ren;
  logic       mem_wen;
  word_t      mem_addr;
  word_t      mem_wdata;
  logic [3:0] mem_strb;
  word_t      mem_rdata;
  logic       mem_ready;

  modport arbiter (
    input  clk, rst, iren, iaddr, dren, dwen, daddr, dstore, dstrb, mem_rdata, mem_ready,
    output iload, ihit, dload, dhit, mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb
  );

  modport mem (
    input  clk, rst, mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb,
    output mem_rdata, mem_ready
  );

  modport tb (
    input  clk, iload, ihit, dload, dhit, mem_ren, mem_wen, mem_addr, mem_wdata, mem_strb,
    output rst, iren, iaddr, dren, dwen, daddr, dstore, dstrb, mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority with fetch anti-starvation; one access in flight,
// strobes from cycle 1 after grant, hit pulse one cycle after mem_ready, minimum 3 cycles/access.
module mem_arbiter
  import common_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [3:0]  dstrb,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic       data_req;
  logic       fetch_starved;

  assign data_req      = dren | dwen;
  assign fetch_starved = iren && (starve_cnt == 4'(STARVE_MAX));

  // The mem_* outputs double as the request registers, so they stay frozen for the whole grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      iload      <= '0;
      dload      <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_strb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req && !fetch_starved) begin
            state     <= GRANT_D;
            mem_ren   <= ~dwen;
            mem_wen   <= dwen;
            mem_addr  <= daddr;
            mem_wdata <= dstore;
            mem_strb  <= dwen ? dstrb : STRB_ALL;
            if (iren && (starve_cnt != 4'(STARVE_MAX))) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (iren) begin
            state      <= GRANT_I;
            mem_ren    <= 1'b1;
            mem_wen    <= 1'b0;
            mem_addr   <= iaddr;
            mem_wdata  <= '0;
            mem_strb   <= STRB_ALL;
            starve_cnt <= '0;
          end
        end
        GRANT_I: begin
          if (mem_ready) begin
            state   <= DONE;
            iload   <= mem_rdata;
            ihit    <= 1'b1;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
          end
        end
        GRANT_D: begin
          if (mem_ready) begin
            state   <= DONE;
            dload   <= mem_rdata;
            dhit    <= 1'b1;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
          end
        end
        DONE: begin
          // No grant here: the finished requester's line may still be high this cycle.
          state <= IDLE;
          ihit  <= 1'b0;
          dhit  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model with its own reference memory.
module tb_mem_arbiter;
  import common_types_pkg::*;

  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus (.clk(clk));

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk       (clk),
    .rst       (bus.rst),
    .iren      (bus.iren),
    .iaddr     (bus.iaddr),
    .iload     (bus.iload),
    .ihit      (bus.ihit),
    .dren      (bus.dren),
    .dwen      (bus.dwen),
    .daddr     (bus.daddr),
    .dstore    (bus.dstore),
    .dstrb     (bus.dstrb),
    .dload     (bus.dload),
    .dhit      (bus.dhit),
    .mem_ren   (bus.mem_ren),
    .mem_wen   (bus.mem_wen),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_strb  (bus.mem_strb),
    .mem_rdata (bus.mem_rdata),
    .mem_ready (bus.mem_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic word_t init_word(int i);
    return (32'(i) * 32'h1111_1111) ^ 32'hA5A5_0000;
  endfunction

  function automatic word_t merge(word_t old_w, word_t new_w, logic [3:0] s);
    word_t r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Pin-level memory: contents follow whatever the DUT actually presents.
  word_t phys [16];
  assign bus.mem_rdata = phys[bus.mem_addr[5:2]];
  always @(posedge clk) begin
    if (bus.rst) begin
      for (int i = 0; i < 16; i++) phys[i] <= init_word(i);
    end else if (bus.mem_ready && bus.mem_wen) begin
      phys[bus.mem_addr[5:2]] <= merge(phys[bus.mem_addr[5:2]], bus.mem_wdata, bus.mem_strb);
    end
  end

  // Reference model: one outstanding transaction record plus the arbitration rules.
  word_t      refm [16];
  bit         t_open, t_is_d, t_is_wr, t_just_hit;
  word_t      t_addr, t_wdata;
  logic [3:0] t_strb;
  int         starves;
  word_t      e_iload, e_dload;
  bit         e_ihit, e_dhit;
  bit         i_pend, d_pend;
  bit         d_wr_kind, d_rd_kind;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) refm[i] = init_word(i);
    t_open = 0; t_is_d = 0; t_is_wr = 0; t_just_hit = 0;
    t_addr = '0; t_wdata = '0; t_strb = '0;
    starves = 0;
    e_iload = '0; e_dload = '0; e_ihit = 0; e_dhit = 0;
  endtask

  task automatic model_step();
    word_t rd;
    if (bus.rst) begin
      model_reset();
      return;
    end
    e_ihit = 0;
    e_dhit = 0;
    if (t_just_hit) begin
      t_just_hit = 0;
    end else if (t_open) begin
      if (bus.mem_ready) begin
        rd = refm[t_addr[5:2]];
        if (t_is_wr) refm[t_addr[5:2]] = merge(rd, t_wdata, t_strb);
        if (t_is_d) begin e_dload = rd; e_dhit = 1; end
        else        begin e_iload = rd; e_ihit = 1; end
        t_open = 0;
        t_just_hit = 1;
      end
    end else if ((bus.dren || bus.dwen) && !(bus.iren && starves == SM)) begin
      t_open = 1; t_is_d = 1; t_is_wr = bus.dwen;
      t_addr = bus.daddr; t_wdata = bus.dstore;
      t_strb = bus.dwen ? bus.dstrb : 4'hF;
      if (bus.iren && starves < SM) starves++;
    end else if (bus.iren) begin
      t_open = 1; t_is_d = 0; t_is_wr = 0;
      t_addr = bus.iaddr; t_wdata = '0; t_strb = 4'hF;
      starves = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ihit",      32'(bus.ihit),    32'(e_ihit));
    chk("dhit",      32'(bus.dhit),    32'(e_dhit));
    chk("mem_ren",   32'(bus.mem_ren), 32'(t_open && !t_is_wr));
    chk("mem_wen",   32'(bus.mem_wen), 32'(t_open && t_is_wr));
    chk("mem_addr",  bus.mem_addr,     t_addr);
    chk("mem_wdata", bus.mem_wdata,    t_wdata);
    chk("mem_strb",  32'(bus.mem_strb), 32'(t_strb));
    chk("iload",     bus.iload,        e_iload);
    chk("dload",     bus.dload,        e_dload);
  endtask

  function automatic word_t rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // Requesters hold their level until the model's hit, occasionally flushing mid-flight.
  // Address/data inputs are rescrambled every cycle to prove they are ignored once granted.
  task automatic drive(input bit r, input int p_i, input int p_d);
    int k;
    bus.rst = r;
    if (r) begin
      i_pend = 0; d_pend = 0;
    end else begin
      if (e_ihit || (i_pend && $urandom_range(0, 99) < 2)) i_pend = 0;
      else if (!i_pend && $urandom_range(0, 99) < p_i)      i_pend = 1;
      if (e_dhit || (d_pend && $urandom_range(0, 99) < 2)) d_pend = 0;
      else if (!d_pend && $urandom_range(0, 99) < p_d) begin
        d_pend = 1;
        k = $urandom_range(0, 99);
        d_wr_kind = (k < 45);
        d_rd_kind = (k >= 40);
      end
    end
    bus.iren      = i_pend;
    bus.dren      = d_pend && d_rd_kind;
    bus.dwen      = d_pend && d_wr_kind;
    bus.iaddr     = rand_addr();
    bus.daddr     = rand_addr();
    bus.dstore    = $urandom;
    bus.dstrb     = 4'($urandom_range(0, 15));
    bus.mem_ready = !r && ($urandom_range(0, 2) == 0);
  endtask

  task automatic do_cycle(input bit r, input int p_i, input int p_d);
    drive(r, p_i, p_d);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  bit did_mid_rst = 0;

  initial begin
    model_reset();
    i_pend = 0; d_pend = 0; d_wr_kind = 0; d_rd_kind = 1;
    do_cycle(1'b1, 0, 0);
    do_cycle(1'b1, 0, 0);
    // Mixed traffic, with one reset landing in the middle of a data grant.
    for (int c = 0; c < 1500; c++) begin
      if (c > 700 && !did_mid_rst && t_open && t_is_d && !t_just_hit) begin
        did_mid_rst = 1;
        do_cycle(1'b1, 0, 0);
      end else begin
        do_cycle(1'b0, 30, 30);
      end
    end
    // Saturated traffic: data re-requests immediately, exercising the starvation limit.
    for (int c = 0; c < 1500; c++) do_cycle(1'b0, 100, 100);
    // Sparse traffic: mostly isolated single accesses.
    for (int c = 0; c < 600; c++) do_cycle(1'b0, 5, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between the instruction fetch requester and the data (load/store) requester of the pipeline. Grants one transaction at a time, holds the grant until memory completes, and returns the one-cycle `ihit`/`dhit` pulses that the hazard unit uses to release pipeline stalls. Data has priority; a starvation counter guarantees forward progress for fetch.

## Interface

Parameters:
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch waits; range 1–15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `iren`  in  1  fetch read request; level, held until `ihit`
- `iaddr`  in  32  fetch address, word aligned
- `iload`  out  32  fetched instruction; valid while `ihit`=1
- `ihit`  out  1  fetch complete; one-cycle pulse
- `dren`  in  1  data read request; level, held until `dhit`
- `dwen`  in  1  data write request; level, held until `dhit`
- `daddr`  in  32  data address
- `dstore`  in  32  store data
- `dstrb`  in  4  store byte strobes
- `dload`  out  32  load data; valid while `dhit`=1
- `dhit`  out  1  data access complete; one-cycle pulse
- `mem_ren`  out  1  memory read strobe
- `mem_wen`  out  1  memory write strobe
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_strb`  out  4  memory byte strobes; 4'hF on reads
- `mem_rdata`  in  32  memory read data; sampled when `mem_ready`=1
- `mem_ready`  in  1  memory completes current access this cycle

## Operation

- States: `IDLE`, `GRANT_I`, `GRANT_D`, `DONE`.
- `IDLE`:
  - If (`dren`|`dwen`) and not (`iren` and `starve_cnt`==`STARVE_MAX`): go to `GRANT_D`.
  - Else if `iren`: go to `GRANT_I`.
  - On either grant, latch address, write data and strobes into request registers.
- `GRANT_D` / `GRANT_I`:
  - `mem_*` outputs are driven only from the request registers; requester inputs are ignored once granted.
  - Hold state until `mem_ready`, then capture `mem_rdata` into `dload` or `iload`, go to `DONE`.
- `DONE`: assert `ihit` or `dhit` (registered, matching the completed grant) for exactly one cycle, then go to `IDLE`. No grant is issued in `DONE`, so a request line still high from the finished access is never re-served.
- `dren`&`dwen` both set: treated as a write (`mem_wen` only). This case is illegal upstream.
- `starve_cnt` (4 bits):
  - Cleared on every `GRANT_I` and on `rst`.
  - Increments on each `GRANT_D` entry while `iren`=1.
  - Saturates at `STARVE_MAX`.
- A request dropped mid-transaction (e.g. fetch flushed by a branch): the access still completes and the hit still pulses; the requester ignores it.
- `iload`/`dload` hold their last captured value outside hit cycles.

## Timing

- Reset: state `IDLE`, `starve_cnt`=0. All outputs 0: `ihit`, `dhit`, `mem_ren`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_strb`, `iload`, `dload`. Any in-flight access is abandoned; the memory is reset on the same `rst`.
- Request sampled in `IDLE` at cycle 0 → `mem_ren`/`mem_wen` asserted from cycle 1.
- `mem_ready` at cycle k → strobes drop and hit pulses in cycle k+1 → `IDLE` at k+2.
- Zero-wait memory (`mem_ready` in cycle 1): hit at cycle 2, next grant decided at cycle 3, giving a minimum of 3 cycles per access.
- Strobes, address and data stay constant for the entire grant.
- `mem_ready` outside a grant state is ignored.

## Structure

- Add to `common_types_pkg`:
  - `word_t` (32-bit), if not already present.
  - `arb_state_t` enum {`IDLE`, `GRANT_I`, `GRANT_D`, `DONE`}.
- Add a `mem_arbiter_if` interface with modports `arbiter`, `mem`, `tb`, following existing interface practice.
- Single module; no sub-module needed. The starvation counter is inline.

## Test plan

- Fetch only: `iren`=1, `iaddr`=0x100, memory returns 0x00000013 after 2 wait cycles → `mem_ren`=1 with addr 0x100 for 3 cycles, then `ihit`=1 with `iload`=0x13 for exactly one cycle.
- Simultaneous `iren` and `dren` (`daddr`=0x2000) in `IDLE` → `GRANT_D` first, `dhit` pulses, then `GRANT_I`, then `ihit`; hits never overlap.
- Starvation with `STARVE_MAX`=4: `dren` held continuously, `iren`=1 → exactly 4 data grants, then one fetch grant, then the counter restarts.
- Store: `dwen`=1, `dstore`=0xDEADBEEF, `dstrb`=4'b0011; change `daddr` mid-grant → memory sees the original address, `mem_wen`=1, strobes 0011; `dhit` one cycle; no read strobe.
- Reset mid-grant: assert `rst` during `GRANT_D` → next cycle all outputs 0, state `IDLE`, no `dhit` ever emitted for that access.
- Flushed fetch: drop `iren` during `GRANT_I` → access completes, `ihit` still pulses once, and no new grant is issued in `DONE`.
